// File: rtl/hour_display_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hour_display_scan: two-digit multiplexed 7-segment hour display with     |
// | blink and invalid-hour indication.                 Revision: 1.0         |
// +--------------------------------------------------------------------------+
module hour_display_scan #(
   parameter int SCAN_DIV  = 1000,
   parameter int BLINK_DIV = 128
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic [5:0] hour_bcd,
   input  logic       load,
   input  logic       blink_en,
   output logic [6:0] seg,
   output logic [1:0] dig,
   output logic       err
);

   localparam logic [15:0] c_pre_max   = 16'(SCAN_DIV - 1);
   localparam logic [9:0]  c_blink_max = 10'(BLINK_DIV - 1);
   localparam logic [6:0]  c_seg_e     = 7'b1001111;

   typedef enum logic [1:0] {
      ST_ONES = 2'd0,
      ST_GAP1 = 2'd1,
      ST_TENS = 2'd2,
      ST_GAP2 = 2'd3
   } state_t;

   state_t      r_state;
   logic [5:0]  r_shadow;
   logic [15:0] r_pre;
   logic [9:0]  r_bcnt;
   logic        r_phase;

   logic [3:0]  w_ones;
   logic [3:0]  w_tens;
   logic        w_invalid;
   logic        w_tick;
   logic [6:0]  w_seg_nxt;
   logic [1:0]  w_dig_nxt;

   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b1111110;
         4'd1:    p = 7'b0110000;
         4'd2:    p = 7'b1101101;
         4'd3:    p = 7'b1111001;
         4'd4:    p = 7'b0110011;
         4'd5:    p = 7'b1011011;
         4'd6:    p = 7'b1011111;
         4'd7:    p = 7'b1110000;
         4'd8:    p = 7'b1111111;
         4'd9:    p = 7'b1111011;
         default: p = 7'b0000000;
      endcase
      return p;
   endfunction

   assign w_ones    = r_shadow[3:0];
   assign w_tens    = {2'b00, r_shadow[5:4]};
   assign w_invalid = (w_ones > 4'd9) || (w_tens == 4'd3) ||
                      ((w_tens == 4'd2) && (w_ones > 4'd3));
   assign w_tick    = (r_pre == c_pre_max);

   // Next display value is derived entirely from pre-edge state.
   always_comb begin
      w_seg_nxt = 7'b0000000;
      w_dig_nxt = 2'b00;
      case (r_state)
         ST_ONES: begin
            w_dig_nxt = 2'b01;
            w_seg_nxt = w_invalid ? c_seg_e : seg_pattern(w_ones);
         end
         ST_TENS: begin
            if (w_invalid) begin
               w_dig_nxt = 2'b10;
               w_seg_nxt = c_seg_e;
            end else if (w_tens != 4'd0) begin
               w_dig_nxt = 2'b10;
               w_seg_nxt = seg_pattern(w_tens);
            end
         end
         default: begin
            w_dig_nxt = 2'b00;
            w_seg_nxt = 7'b0000000;
         end
      endcase
      if (blink_en && r_phase) begin
         w_dig_nxt = 2'b00;
         w_seg_nxt = 7'b0000000;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state  <= ST_ONES;
         r_shadow <= 6'd0;
         r_pre    <= 16'd0;
         r_bcnt   <= 10'd0;
         r_phase  <= 1'b0;
         seg      <= 7'b0000000;
         dig      <= 2'b00;
         err      <= 1'b0;
      end else begin
         if (load)
            r_shadow <= hour_bcd;

         r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;

         if (w_tick) begin
            case (r_state)
               ST_ONES: r_state <= ST_GAP1;
               ST_GAP1: r_state <= ST_TENS;
               ST_TENS: r_state <= ST_GAP2;
               default: r_state <= ST_ONES;
            endcase
         end

         if (!blink_en) begin
            r_bcnt  <= 10'd0;
            r_phase <= 1'b0;
         end else if (w_tick) begin
            if (r_bcnt == c_blink_max) begin
               r_bcnt  <= 10'd0;
               r_phase <= ~r_phase;
            end else begin
               r_bcnt <= r_bcnt + 10'd1;
            end
         end

         seg <= w_seg_nxt;
         dig <= w_dig_nxt;
         err <= w_invalid;
      end
   end

endmodule
`default_nettype wire

// File: doc/hour_display_scan.md
HOUR_DISPLAY_SCAN -- requirements
Module: hour_display_scan

Interface
REQ-001 SCAN_DIV, default 1000: clk cycles per scan tick; legal range 1..65535.
REQ-002 BLINK_DIV, default 128: scan ticks per blink half-period; legal range 1..1023.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 clr_n  input  1  reset, asynchronous, active-low.
REQ-005 hour_bcd  input  6  BCD hour {tens[1:0], ones[3:0]}; nominal range 00..23.
REQ-006 load  input  1  when 1 at a clk edge, hour_bcd is captured into the shadow register.
REQ-007 blink_en  input  1  when 1, the display flashes at the blink rate.
REQ-008 seg  output  7  segments {a,b,c,d,e,f,g}, active-high, registered.
REQ-009 dig  output  2  digit enables, active-high, registered; dig[1]=tens, dig[0]=ones; never both 1.
REQ-010 err  output  1  1 while the shadow value is not a legal hour, registered.

Function
REQ-011 Shadow register (6 bits) SHALL load hour_bcd on any clk edge with load=1; otherwise it holds; display uses only the shadow.
REQ-012 Shadow is invalid if ones>9, tens==3, or (tens==2 and ones>3).
REQ-013 err SHALL equal shadow invalidity, updated on the edge after the shadow changes (one cycle after load).
REQ-014 Prescaler counts 0..SCAN_DIV-1 and wraps; tick=1 for the one cycle in which the count equals SCAN_DIV-1; SCAN_DIV=1 gives tick every cycle.
REQ-015 Scan FSM states: ONES -> GAP1 -> TENS -> GAP2 -> ONES, advancing one state per tick; no other transitions.
REQ-016 ONES: dig=01, seg=pattern(ones); TENS: dig=10, seg=pattern(tens); GAP1/GAP2: dig=00, seg=0000000.
REQ-017 Patterns a..g: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-018 Leading-zero blanking: valid shadow with tens==0 SHALL give dig=00, seg=0000000 in TENS.
REQ-019 Invalid shadow: ONES and TENS both show "E" = 1001111, with no leading-zero blanking.
REQ-020 Blink counter SHALL count ticks 0..BLINK_DIV-1 and toggle blink phase on wrap, but only while blink_en=1.
REQ-021 blink_en=0 SHALL clear the blink counter and phase on the next edge.
REQ-022 Phase=1 with blink_en=1 SHALL force dig=00, seg=0000000 while the FSM keeps advancing.
REQ-023 Outputs SHALL be registered from the state present before each edge, so a load or state change is visible one cycle later.
REQ-024 A load mid-scan SHALL NOT restart the prescaler or FSM; the current state displays the new value.
REQ-025 Simultaneous load and tick SHALL capture the new value and advance the state on the same edge.

Reset
REQ-026 clr_n=0 SHALL immediately force shadow=000000, prescaler=0, FSM=ONES, blink counter=0, phase=0, seg=0000000, dig=00, err=0.
REQ-027 On the first clk edge after clr_n rises: dig=01, seg=1111110 (ones digit showing 0).
REQ-028 Reset asserted mid-scan or mid-blink SHALL abandon all activity with no partial output.

Verification (SCAN_DIV=4, BLINK_DIV=2)
REQ-029 Reset release, no load -> dig=01 seg=1111110 for cycles 1-4, then dig=00 for 4, then dig=00 for 4 (tens blanked), then dig=00 for 4, then repeat.
REQ-030 load hour_bcd=100011 (23) -> ONES dig=01 seg=1111001; TENS dig=10 seg=1101101; err=0.
REQ-031 load hour_bcd=001010 (ones=10) -> err=1 one cycle later; ONES and TENS both seg=1001111.
REQ-032 load 100100 (24) then load 011001 (19) mid-TENS -> err 1 then 0; TENS switches from 1001111 to 0110000 one cycle after the second load, no FSM restart.
REQ-033 blink_en=1 with hour 12 -> 2 ticks normal, 2 ticks dig=00 seg=0; blink_en=0 mid-dark -> normal display on the next cycle.
REQ-034 clr_n pulsed low during TENS of hour 21 -> dig=00, seg=0, err=0 immediately; after release, ones shows 0.
